// File: rtl/rom_pkg.sv
// ----------------------------------------------------------------------------
// rom_pkg
// Shared definitions for the ROM burst reader:
//   ADDR_W / DATA_W / LEN_W : ROM address, ROM data and burst-length widths
//   rd_state_e              : sequencer states (IDLE, FETCH, DRAIN)
//   rom_word_t              : one buffered word {data, last}
//   addr_inc()              : modulo-2^ADDR_W address increment
// ----------------------------------------------------------------------------
package rom_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 4;
  localparam int LEN_W  = ADDR_W + 1;  // one extra bit so a full 256-word burst fits

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } rom_word_t;

  // Natural overflow of the ADDR_W-bit sum gives the 255 -> 0 wrap.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] addr);
    return addr + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/rom_burst_reader_if.sv
// ----------------------------------------------------------------------------
// rom_burst_reader_if
// Bundles every non-clock/reset signal of the burst reader.
//   command : start, base_addr, len
//   ROM     : rom_addr (to ROM), rom_data (from ROM, combinational)
//   stream  : m_valid, m_ready, m_data, m_last
//   status  : busy, done
// Modports:
//   slave  - the burst reader itself
//   master - the environment (command source, ROM, stream sink)
// ----------------------------------------------------------------------------
interface rom_burst_reader_if;
  import rom_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              busy;
  logic              done;

  modport slave (
    input  start, base_addr, len, rom_data, m_ready,
    output rom_addr, m_valid, m_data, m_last, busy, done
  );

  modport master (
    output start, base_addr, len, rom_data, m_ready,
    input  rom_addr, m_valid, m_data, m_last, busy, done
  );

endinterface

// File: rtl/rom_skid_fifo.sv
// ----------------------------------------------------------------------------
// rom_skid_fifo
// Two-entry FIFO of rom_word_t. Entry 0 is always the head, so the head
// word comes straight from a flop and stays stable until it is popped.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   push        : write push_word (ignored when full and not popping)
//   push_word   : word to store
//   pop         : discard head (ignored when empty)
//   head_word   : current head entry
//   full, empty : occupancy flags
//   count       : occupancy 0..2
// ----------------------------------------------------------------------------
module rom_skid_fifo
  import rom_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  rom_word_t push_word,
  input  logic      pop,
  output rom_word_t head_word,
  output logic      full,
  output logic      empty,
  output logic [1:0] count
);

  rom_word_t  slot0_q, slot0_d;
  rom_word_t  slot1_q, slot1_d;
  logic [1:0] count_q, count_d;
  logic       do_push_s;
  logic       do_pop_s;

  // Next-state for the two slots and the occupancy counter.
  always_comb begin
    slot0_d   = slot0_q;
    slot1_d   = slot1_q;
    count_d   = count_q;
    do_pop_s  = pop && (count_q != 2'd0);
    // A push into a full FIFO is only legal when the head leaves this cycle.
    do_push_s = push && ((count_q != 2'd2) || do_pop_s);
    case ({do_push_s, do_pop_s})
      2'b10: begin
        if (count_q == 2'd0) begin
          slot0_d = push_word;
        end else begin
          slot1_d = push_word;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; the new word lands behind whatever remains.
        if (count_q == 2'd1) begin
          slot0_d = push_word;
        end else begin
          slot0_d = slot1_q;
          slot1_d = push_word;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Slot and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign head_word = slot0_q;
  assign full      = (count_q == 2'd2);
  assign empty     = (count_q == 2'd0);
  assign count     = count_q;

endmodule

// File: rtl/rom_burst_reader.sv
// ----------------------------------------------------------------------------
// rom_burst_reader
// Accepts a {base_addr, len} burst command, walks the ROM address one word
// per cycle, and streams the returned words out on a valid/ready port with a
// last marker. A 2-entry FIFO absorbs downstream backpressure so the fetch
// side keeps one word per cycle whenever the sink is ready.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (aborts any burst, no done)
//   bus   : rom_burst_reader_if.slave (command, ROM, stream and status)
// ----------------------------------------------------------------------------
module rom_burst_reader
  import rom_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  rom_burst_reader_if.slave    bus
);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              push_s;
  logic              pop_s;
  rom_word_t         push_word_s;
  rom_word_t         head_word_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [1:0]        fifo_count_s;

  rom_skid_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_word (push_word_s),
    .pop       (pop_s),
    .head_word (head_word_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Sequencer next-state, fetch control and status pulses.
  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    remaining_d = remaining_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    push_s      = 1'b0;
    pop_s       = (!fifo_empty_s) && bus.m_ready;
    // rom_data is combinational from rom_addr_q, so it belongs to the word
    // being fetched this cycle; remaining_q counts that word too.
    push_word_s.data = bus.rom_data;
    push_word_s.last = (remaining_q == LEN_W'(1));

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.len != {LEN_W{1'b0}}) begin
            rom_addr_d  = bus.base_addr;
            remaining_d = bus.len;
            busy_d      = 1'b1;
            state_d     = FETCH;
          end else begin
            // Empty burst completes immediately without ever going busy.
            done_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end

      FETCH: begin
        if (remaining_q == {LEN_W{1'b0}}) begin
          // Unreachable in normal operation; never let the counter wrap.
          state_d = DRAIN;
        end else if ((!fifo_full_s) || pop_s) begin
          push_s      = 1'b1;
          rom_addr_d  = addr_inc(rom_addr_q);
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = DRAIN;
          end else begin
            state_d = FETCH;
          end
        end else begin
          // Stalled: rom_addr stays on the next unfetched word.
          state_d = FETCH;
        end
      end

      DRAIN: begin
        // Finish as the last word leaves so done/idle line up with the
        // cycle after the final handshake.
        if ((fifo_count_s == 2'd0) || ((fifo_count_s == 2'd1) && pop_s)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, address, counter and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rom_addr_q  <= {ADDR_W{1'b0}};
      remaining_q <= {LEN_W{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.m_valid  = !fifo_empty_s;
  assign bus.m_data   = head_word_s.data;
  assign bus.m_last   = head_word_s.last;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
